// File: rtl/loader_pkg.sv
// Shared definitions for the UART-to-IRAM boot loader: FSM encoding and frame constants.
package loader_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLen,
    StDataHi,
    StDataLo,
    StCsum
  } state_e;

  localparam logic [7:0] HEADER_BYTE = 8'hA5;

endpackage

// File: rtl/rx_timeout.sv
// Inter-byte watchdog: counts enabled cycles without a kick and flags expiry once the
// count reaches TIMEOUT_CYCLES.
module rx_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic kick,
  output logic expired
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CntW-1:0] Limit = CntW'(TIMEOUT_CYCLES);

  logic [CntW-1:0] cnt_q, cnt_d;

  // Expiry ignores kick so a byte landing on the expiry cycle cannot rescue the frame.
  assign expired = en && (cnt_q == Limit);

  always_comb begin
    cnt_d = cnt_q;
    if (!en || kick || expired) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/iram_loader.sv
// Receives a framed program image byte-by-byte from the UART and writes it into
// instruction RAM, holding the CPU while a frame is in flight.
module iram_loader
  import loader_pkg::*;
#(
  parameter int unsigned WIDTH          = 16,
  parameter int unsigned IRAM_ADDR_BITS = 8,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [7:0]                rx_data,
  input  logic                      rx_valid,
  output logic [IRAM_ADDR_BITS-1:0] iram_wa,
  output logic                      iram_wen,
  output logic [WIDTH-1:0]          iram_din,
  output logic                      cpu_hold,
  output logic                      done,
  output logic                      err
);

  state_e                    state_q, state_d;
  logic [7:0]                len_q, len_d;
  logic [7:0]                idx_q, idx_d;
  logic [IRAM_ADDR_BITS-1:0] addr_q, addr_d;
  logic [7:0]                hi_q, hi_d;
  logic [7:0]                csum_q, csum_d;
  logic                      wen_q, wen_d;
  logic [IRAM_ADDR_BITS-1:0] wa_q, wa_d;
  logic [WIDTH-1:0]          din_q, din_d;
  logic                      done_q, done_d;
  logic                      err_q, err_d;
  logic                      timeout;

  rx_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .reset  (reset),
    .en     (state_q != StIdle),
    .kick   (rx_valid),
    .expired(timeout)
  );

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    idx_d   = idx_q;
    addr_d  = addr_q;
    hi_d    = hi_q;
    csum_d  = csum_q;
    wen_d   = 1'b0;
    wa_d    = wa_q;
    din_d   = din_q;
    done_d  = 1'b0;
    err_d   = err_q;

    if (timeout) begin
      state_d = StIdle;
      err_d   = 1'b1;
    end else if (rx_valid) begin
      unique case (state_q)
        StIdle: begin
          if (rx_data == HEADER_BYTE) begin
            state_d = StLen;
            err_d   = 1'b0;
            idx_d   = '0;
            addr_d  = '0;
            csum_d  = '0;
          end
        end
        StLen: begin
          len_d   = rx_data;
          state_d = StDataHi;
        end
        StDataHi: begin
          hi_d    = rx_data;
          csum_d  = csum_q ^ rx_data;
          state_d = StDataLo;
        end
        StDataLo: begin
          csum_d = csum_q ^ rx_data;
          wen_d  = 1'b1;
          wa_d   = addr_q;
          din_d  = WIDTH'({hi_q, rx_data});
          addr_d = addr_q + IRAM_ADDR_BITS'(1);
          idx_d  = idx_q + 8'd1;
          // 8-bit wrap makes a length byte of 0 terminate after word 256.
          state_d = (idx_q == len_q - 8'd1) ? StCsum : StDataHi;
        end
        StCsum: begin
          if (rx_data == csum_q) begin
            done_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
          state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      len_q   <= '0;
      idx_q   <= '0;
      addr_q  <= '0;
      hi_q    <= '0;
      csum_q  <= '0;
      wen_q   <= 1'b0;
      wa_q    <= '0;
      din_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      addr_q  <= addr_d;
      hi_q    <= hi_d;
      csum_q  <= csum_d;
      wen_q   <= wen_d;
      wa_q    <= wa_d;
      din_q   <= din_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign iram_wa  = wa_q;
  assign iram_wen = wen_q;
  assign iram_din = din_q;
  assign cpu_hold = (state_q != StIdle);
  assign done     = done_q;
  assign err      = err_q;

endmodule

// File: tb/tb_iram_loader.sv
// Bench for iram_loader: frame-level reference model checked every cycle, directed
// frame table, hand-written corner sequences and randomized frame traffic.
module tb_iram_loader;

  localparam int unsigned TO = 100;

  logic        clk;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [7:0]  iram_wa;
  logic        iram_wen;
  logic [15:0] iram_din;
  logic        cpu_hold;
  logic        done;
  logic        err;

  iram_loader #(
    .WIDTH         (16),
    .IRAM_ADDR_BITS(8),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .rx_data (rx_data),
    .rx_valid(rx_valid),
    .iram_wa (iram_wa),
    .iram_wen(iram_wen),
    .iram_din(iram_din),
    .cpu_hold(cpu_hold),
    .done    (done),
    .err     (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: frame parser by byte position within the frame.
  bit          m_in_frame, m_got_len;
  int          m_nwords, m_pos, m_next_addr, m_quiet;
  logic [7:0]  m_hi, m_xsum;
  bit          exp_wen, exp_done, exp_err;
  logic [7:0]  exp_wa;
  logic [15:0] exp_din;

  function automatic void model_reset();
    m_in_frame = 0; m_got_len = 0; m_nwords = 0; m_pos = 0; m_next_addr = 0; m_quiet = 0;
    m_hi = 0; m_xsum = 0;
    exp_wen = 0; exp_done = 0; exp_err = 0; exp_wa = 0; exp_din = 0;
  endfunction

  function automatic void model_step(input bit v, input logic [7:0] d);
    exp_wen  = 0;
    exp_done = 0;
    if (m_in_frame && m_quiet == int'(TO)) begin
      m_in_frame = 0;
      m_quiet    = 0;
      exp_err    = 1;
    end else if (v) begin
      m_quiet = 0;
      if (!m_in_frame) begin
        if (d == 8'hA5) begin
          m_in_frame = 1; m_got_len = 0; exp_err = 0; m_xsum = 0; m_pos = 0; m_next_addr = 0;
        end
      end else if (!m_got_len) begin
        m_got_len = 1;
        m_nwords  = (d == 8'h00) ? 256 : int'(d);
      end else if (m_pos < 2 * m_nwords) begin
        m_xsum = m_xsum ^ d;
        if (m_pos % 2 == 0) begin
          m_hi = d;
        end else begin
          exp_wen = 1;
          exp_wa  = 8'(m_next_addr);
          exp_din = {m_hi, d};
          m_next_addr++;
        end
        m_pos++;
      end else begin
        if (d == m_xsum) exp_done = 1;
        else exp_err = 1;
        m_in_frame = 0;
      end
    end else if (m_in_frame) begin
      m_quiet++;
    end
  endfunction

  logic [23:0] act_wr[$];
  int          act_done;

  task automatic compare_outputs(input string name);
    check(name, 64'({iram_wen, iram_wa, iram_din, done, err, cpu_hold}),
          64'({exp_wen, exp_wa, exp_din, exp_done, exp_err, m_in_frame}));
  endtask

  task automatic step(input bit v, input logic [7:0] d);
    @(negedge clk);
    rx_valid = v;
    rx_data  = d;
    @(posedge clk);
    model_step(v, d);
    #1;
    compare_outputs("cycle_outputs");
    if (iram_wen) act_wr.push_back({iram_wa, iram_din});
    if (done) act_done++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset    = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    #1;
    model_reset();
    compare_outputs("reset_async");
    @(posedge clk);
    #1;
    compare_outputs("reset_held");
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] b[$], input int gap);
    foreach (b[i]) begin
      step(1'b1, b[i]);
      repeat (gap) step(1'b0, 8'h00);
    end
  endtask

  typedef struct {
    string            name;
    int               nb;
    logic [0:7][7:0]  b;
    int               nw;
    logic [0:1][23:0] w;
    int               exp_done;
    logic             exp_err;
  } vec_t;

  vec_t        tbl[4];
  logic [7:0]  fq[$];
  int          n, r, gap;
  logic [7:0]  xs, lo_b;

  initial begin
    reset    = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    model_reset();

    tbl[0] = '{"good_frame", 7, {8'hA5, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h40, 8'h00},
               2, {24'h00_1234, 24'h01_ABCD}, 1, 1'b0};
    tbl[1] = '{"bad_csum", 7, {8'hA5, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h41, 8'h00},
               2, {24'h00_1234, 24'h01_ABCD}, 0, 1'b1};
    tbl[2] = '{"junk_lead", 8, {8'h00, 8'hFF, 8'h33, 8'hA5, 8'h01, 8'h00, 8'h07, 8'h07},
               1, {24'h00_0007, 24'h0}, 1, 1'b0};
    tbl[3] = '{"a5_as_data", 5, {8'hA5, 8'h01, 8'hA5, 8'hA5, 8'h00, 8'h00, 8'h00, 8'h00},
               1, {24'h00_A5A5, 24'h0}, 1, 1'b0};

    do_reset();

    // Directed frame table; err after bad_csum must persist through junk_lead's lead bytes.
    for (int t = 0; t < 4; t++) begin
      act_wr.delete();
      act_done = 0;
      for (int i = 0; i < tbl[t].nb; i++) begin
        step(1'b1, tbl[t].b[i]);
        step(1'b0, 8'h00);
        if (t == 2 && i == 2) check("err_sticky_junk", 64'(err), 64'(1));
      end
      repeat (2) step(1'b0, 8'h00);
      check({tbl[t].name, "_nwrites"}, 64'(act_wr.size()), 64'(tbl[t].nw));
      for (int k = 0; k < tbl[t].nw && k < act_wr.size(); k++)
        check({tbl[t].name, "_write"}, 64'(act_wr[k]), 64'(tbl[t].w[k]));
      check({tbl[t].name, "_done"}, 64'(act_done), 64'(tbl[t].exp_done));
      check({tbl[t].name, "_err"}, 64'(err), 64'(tbl[t].exp_err));
      check({tbl[t].name, "_hold"}, 64'(cpu_hold), 64'(0));
    end

    // Timeout with a byte arriving exactly on the expiry cycle.
    do_reset();
    act_wr.delete();
    act_done = 0;
    fq = '{8'hA5, 8'h01, 8'h12};
    send_frame(fq, 0);
    repeat (TO) step(1'b0, 8'h00);
    check("timeout_hold_before", 64'(cpu_hold), 64'(1));
    step(1'b1, 8'h34);
    check("timeout_err", 64'(err), 64'(1));
    check("timeout_hold", 64'(cpu_hold), 64'(0));
    check("timeout_nowrite", 64'(act_wr.size()), 64'(0));
    check("timeout_nodone", 64'(act_done), 64'(0));
    fq = '{8'hA5, 8'h01, 8'h00, 8'h07, 8'h07};
    send_frame(fq, 1);
    check("after_timeout_write", 64'(act_wr.size() == 1 ? act_wr[0] : 24'hFFFFFF),
          64'(24'h00_0007));
    check("after_timeout_err", 64'(err), 64'(0));

    // N=0: 256 words of incrementing bytes.
    act_wr.delete();
    act_done = 0;
    fq = '{8'hA5, 8'h00};
    xs = 8'h00;
    for (int i = 0; i < 512; i++) begin
      fq.push_back(8'(i));
      xs = xs ^ 8'(i);
    end
    fq.push_back(xs);
    send_frame(fq, 0);
    step(1'b0, 8'h00);
    check("n0_nwrites", 64'(act_wr.size()), 64'(256));
    for (int k = 0; k < 256 && k < act_wr.size(); k++)
      check("n0_write", 64'(act_wr[k]), 64'({8'(k), 8'(2 * k), 8'(2 * k + 1)}));
    check("n0_done", 64'(act_done), 64'(1));

    // Reset coinciding with the low byte of word 3 must suppress its write.
    act_wr.delete();
    fq = '{8'hA5, 8'h05, 8'h10, 8'h11, 8'h20, 8'h21, 8'h30, 8'h31, 8'h40};
    send_frame(fq, 0);
    check("pre_reset_writes", 64'(act_wr.size()), 64'(3));
    @(negedge clk);
    reset    = 1'b1;
    rx_valid = 1'b1;
    rx_data  = 8'h41;
    #1;
    model_reset();
    compare_outputs("reset_mid_async");
    @(posedge clk);
    #1;
    check("reset_mid_nowen", 64'(iram_wen), 64'(0));
    compare_outputs("reset_mid_outputs");
    @(negedge clk);
    reset    = 1'b0;
    rx_valid = 1'b0;
    act_wr.delete();
    act_done = 0;
    fq = '{8'hA5, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h40};
    send_frame(fq, 0);
    step(1'b0, 8'h00);
    check("post_reset_nwrites", 64'(act_wr.size()), 64'(2));
    check("post_reset_done", 64'(act_done), 64'(1));

    // Randomized frames: junk, random gaps (some straddling the timeout), bad checksums.
    for (int f = 0; f < 40; f++) begin
      fq.delete();
      repeat ($urandom_range(0, 2)) fq.push_back(8'($urandom));
      n = ($urandom_range(0, 9) == 0) ? $urandom_range(7, 20) : $urandom_range(1, 6);
      fq.push_back(8'hA5);
      fq.push_back(8'(n));
      xs = 8'h00;
      for (int i = 0; i < 2 * n; i++) begin
        lo_b = ($urandom_range(0, 7) == 0) ? 8'hA5 : 8'($urandom);
        fq.push_back(lo_b);
        xs = xs ^ lo_b;
      end
      if ($urandom_range(0, 3) == 0) xs = xs ^ 8'($urandom_range(1, 255));
      fq.push_back(xs);
      if ($urandom_range(0, 9) == 0) fq = fq[0:$urandom_range(0, fq.size() - 1)];
      foreach (fq[i]) begin
        r = $urandom_range(0, 99);
        if (r < 70) gap = 0;
        else if (r < 90) gap = $urandom_range(1, 3);
        else if (r < 94) gap = TO - 1;
        else if (r < 97) gap = TO;
        else gap = TO + 1;
        repeat (gap) step(1'b0, 8'($urandom));
        step(1'b1, fq[i]);
      end
    end
    repeat (TO + 5) step(1'b0, 8'h00);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "bench did not complete");
  end

endmodule

// File: doc/iram_loader.md
IRAM_LOADER -- requirements
Module: iram_loader

Interface
REQ-001 Parameter WIDTH, default 16, instruction word width; only 16 is supported (two bytes per word).
REQ-002 Parameter IRAM_ADDR_BITS, default 8, instruction RAM address width.
REQ-003 Parameter TIMEOUT_CYCLES, default 1000000, maximum allowed idle cycles between bytes inside a frame.
REQ-004 clk  input  1  single clock; all logic SHALL be rising-edge clocked.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 rx_data  input  8  received byte from the UART receiver.
REQ-007 rx_valid  input  1  one-cycle strobe; rx_data is valid when this is high.
REQ-008 iram_wa  output  IRAM_ADDR_BITS  instruction RAM write address.
REQ-009 iram_wen  output  1  instruction RAM write enable, one-cycle pulse per word.
REQ-010 iram_din  output  WIDTH  instruction RAM write data.
REQ-011 cpu_hold  output  1  high while a frame is in progress; the top level SHALL use it to hold the processor in reset.
REQ-012 done  output  1  one-cycle pulse on a successful frame.
REQ-013 err  output  1  sticky error flag.

Function
REQ-014 Frame format SHALL be: header 0xA5, length byte N, 2*N data bytes (high byte first, per word), then one checksum byte. N=0 SHALL mean 256 words.
REQ-015 The FSM states SHALL be IDLE, LEN, DATA_HI, DATA_LO and CSUM; state advances only on rx_valid.
REQ-016 IDLE: rx_data=0xA5 -> LEN, cpu_hold=1, err cleared, word index=0, checksum=0. Any other byte SHALL be ignored.
REQ-017 LEN: latch N, then go to DATA_HI.
REQ-018 DATA_HI: latch the high byte, XOR it into the checksum, then go to DATA_LO.
REQ-019 DATA_LO: XOR the byte into the checksum. On the next cycle drive iram_wen=1, iram_din={hi,lo}, iram_wa=index (latency 1 cycle), then increment index.
REQ-020 After word N is written, go to CSUM; otherwise return to DATA_HI.
REQ-021 CSUM: if the byte equals the accumulated XOR, pulse done for 1 cycle. Otherwise set err=1. In both cases go to IDLE and drop cpu_hold in the same cycle.
REQ-022 Words already written SHALL NOT be rolled back on checksum error.
REQ-023 iram_wa SHALL wrap modulo 2^IRAM_ADDR_BITS; with N=256 and IRAM_ADDR_BITS=8 the last write is at 0xFF.
REQ-024 Timeout: in any state other than IDLE, a counter SHALL count cycles without rx_valid and reset on each rx_valid. Reaching TIMEOUT_CYCLES -> err=1, IDLE, cpu_hold=0, no done.
REQ-025 rx_valid coinciding with the timeout cycle: the timeout SHALL take priority and the byte is discarded.
REQ-026 A byte 0xA5 received mid-frame SHALL be treated as data, not as a restart.
REQ-027 Outside the write pulse, iram_wen SHALL be 0; iram_wa and iram_din SHALL hold their last values.
REQ-028 err SHALL remain 1 until the next accepted header or reset.

Reset
REQ-029 On reset: state=IDLE; iram_wa=0, iram_din=0, iram_wen=0; cpu_hold=0, done=0, err=0; index, checksum and timeout counter=0.
REQ-030 Reset asserted mid-frame SHALL abort immediately with no further write pulse, including a pending one.

Structure
REQ-031 The FSM state encoding and the HEADER_BYTE constant (0xA5) SHALL reside in the shared package loader_pkg.
REQ-032 The inter-byte timeout counter SHALL be a sub-module rx_timeout (inputs: clk, reset, en, kick; output: expired; parameter TIMEOUT_CYCLES).

Verification
REQ-033 Bytes A5 02 12 34 AB CD checksum 0x40 -> writes 0x1234@0, 0xABCD@1, done pulse, err=0, cpu_hold=0 after.
REQ-034 Same frame with checksum 0x41 -> both words written, no done, err=1 until the next A5 header.
REQ-035 Bytes 00 FF 33 then A5 01 00 07 07 -> leading bytes ignored; write 0x0007@0; done.
REQ-036 A5 01 12 then silence for TIMEOUT_CYCLES (bench uses 100) -> err=1, IDLE, no write, cpu_hold=0.
REQ-037 N=0 with 512 incrementing bytes -> 256 writes, addresses 0x00..0xFF, done.
REQ-038 Reset during DATA_LO of word 3 -> no iram_wen pulse, all outputs 0; a subsequent valid frame loads correctly.
